// File: rtl/bu_ntt_sched.sv
// bu_ntt_sched -- iterative in-place NTT/INTT scheduler for one shared butterfly.
//
// Walks all N_LOG2 stages of an N = 2**N_LOG2 point transform held in a
// dual-port synchronous RAM. It issues one butterfly per cycle, and then
// waits for the write-back of the stage before the next stage starts.
//
// Ports:
//   clk_i                  clock, rising edge
//   reset_ni               asynchronous active-low reset
//   start_i                start request, sampled only in IDLE
//   mode_i                 1 = forward NTT (CT), 0 = INTT (GS); latched on start
//   busy_o                 transform in progress (ISSUE or DRAIN)
//   done_o                 one-cycle completion pulse
//   ct_mode_o              latched mode, drives the butterfly ct_mode input
//   stage_o                current stage index, 0-based
//   rd_en_o                read strobe for both RAM ports
//   rd_addr1_o/rd_addr2_o  butterfly operand addresses
//   zeta_idx_o             twiddle ROM index, aligned with rd_en_o
//   wr_en_o                write strobe for both RAM ports
//   wr_addr1_o/wr_addr2_o  write-back addresses for the butterfly outputs
module bu_ntt_sched #(
    parameter int N_LOG2     = 8,
    parameter int BU_LATENCY = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      start_i,
    input  logic                      mode_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      ct_mode_o,
    output logic [$clog2(N_LOG2)-1:0] stage_o,
    output logic                      rd_en_o,
    output logic [N_LOG2-1:0]         rd_addr1_o,
    output logic [N_LOG2-1:0]         rd_addr2_o,
    output logic [N_LOG2-1:0]         zeta_idx_o,
    output logic                      wr_en_o,
    output logic [N_LOG2-1:0]         wr_addr1_o,
    output logic [N_LOG2-1:0]         wr_addr2_o
);

    // The RAM read costs one cycle and the butterfly adds BU_LATENCY more.
    localparam int WB_DELAY = 1 + BU_LATENCY;
    localparam int STG_W    = $clog2(N_LOG2);
    localparam int BF_W     = N_LOG2 - 1;
    localparam int CNT_W    = $clog2(WB_DELAY + 1);
    localparam int SR_W     = 2 * N_LOG2 + 1;

    localparam logic [STG_W-1:0]  LAST_STAGE = STG_W'(N_LOG2 - 1);
    localparam logic [BF_W-1:0]   LAST_BFLY  = '1;
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(WB_DELAY);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [N_LOG2-1:0] ONE        = N_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q,  mode_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [BF_W-1:0]   bfly_q,  bfly_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            stage_q <= '0;
            bfly_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    mode_d  = mode_i;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            S_ISSUE: begin
                bfly_d = bfly_q + 1'b1;
                if (bfly_q == LAST_BFLY) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                // WB_DELAY drain cycles: the last write of this stage lands in
                // the final drain cycle, so the next read is hazard-free.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 1'b1;
                        bfly_d  = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    logic [STG_W-1:0]  len_log2;
    logic [N_LOG2-1:0] bfly_w;
    logic [N_LOG2-1:0] len_w;
    logic [N_LOG2-1:0] grp;
    logic [N_LOG2-1:0] off;
    logic [N_LOG2-1:0] a1;
    logic [N_LOG2-1:0] a2;
    logic [N_LOG2-1:0] zeta;
    logic              rd_en;

    always_comb begin
        rd_en  = (state_q == S_ISSUE);
        busy_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done_o = (state_q == S_DONE);

        // CT halves the span every stage, GS doubles it.
        len_log2 = mode_q ? (LAST_STAGE - stage_q) : stage_q;
        bfly_w   = N_LOG2'(bfly_q);
        len_w    = ONE << len_log2;
        grp      = bfly_w >> len_log2;
        off      = bfly_w & (len_w - ONE);
        a1       = ((grp << len_log2) << 1) | off;
        // addr1 has the len bit clear, so OR is the same as adding len.
        a2       = a1 | len_w;
        // N/(2*len) + group
        zeta     = (ONE << (LAST_STAGE - len_log2)) + grp;

        rd_en_o    = rd_en;
        rd_addr1_o = rd_en ? a1   : '0;
        rd_addr2_o = rd_en ? a2   : '0;
        zeta_idx_o = rd_en ? zeta : '0;
        ct_mode_o  = mode_q;
        stage_o    = stage_q;
    end

    // ---------------------------------------------------------------- write-back delay line
    // {valid, addr1, addr2} travels WB_DELAY cycles alongside the data path and
    // is never stalled, so write-back tracks the read issue exactly.
    logic [SR_W-1:0] sr_q [WB_DELAY];

    generate
        for (genvar gi = 0; gi < WB_DELAY; gi++) begin : g_wb
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    sr_q[gi] <= '0;
                end else begin
                    if (gi == 0) begin
                        sr_q[gi] <= {rd_en_o, rd_addr1_o, rd_addr2_o};
                    end else begin
                        sr_q[gi] <= sr_q[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        wr_en_o    = sr_q[WB_DELAY-1][SR_W-1];
        wr_addr1_o = sr_q[WB_DELAY-1][2*N_LOG2-1:N_LOG2];
        wr_addr2_o = sr_q[WB_DELAY-1][N_LOG2-1:0];
    end

endmodule
